bp_cce_fetch_ctrl: RTL

//  CCE microcode fetch sequencer. Issues instruction-RAM reads, predecodes each returned word
//  (static branch prediction), buffers up to two fetched instructions for execute, and redirects on
//  the mispredict/next-PC result from the execute-stage branch unit. Sustains 1 instr/cycle.

---
 rtl/bp_cce_pkg.sv | 13 +
 rtl/bp_cce_fetch_buffer.sv | 67 ++++++
 rtl/bp_cce_fetch_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/bp_cce_pkg.sv
// Shared CCE definitions: microcode predecode field positions and fetch FSM states.
package bp_cce_pkg;

  localparam int cce_inst_branch_bit_lp     = 31;
  localparam int cce_inst_pred_taken_bit_lp = 30;
  localparam int cce_inst_target_lsb_lp     = 0;

  typedef enum logic {
    e_fetch_wait_start,
    e_fetch_run
  } bp_cce_fetch_state_e;

endpackage

// File: rtl/bp_cce_fetch_buffer.sv
// Two-entry FIFO of predecoded microcode instructions {inst, pc, pred}; head is entry 0.
module bp_cce_fetch_buffer
  import bp_cce_pkg::*;
#(
  parameter int inst_width_p = 32,
  parameter int pc_width_p   = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    flush_i,
  input  logic                    enq_i,
  input  logic [inst_width_p-1:0] enq_inst_i,
  input  logic [pc_width_p-1:0]   enq_pc_i,
  input  logic                    enq_pred_i,
  input  logic                    deq_i,
  output logic                    v_o,
  output logic [inst_width_p-1:0] inst_o,
  output logic [pc_width_p-1:0]   pc_o,
  output logic                    pred_o,
  output logic [1:0]              count_o
);

  localparam int entry_width_lp = inst_width_p + pc_width_p + 1;

  logic [entry_width_lp-1:0] head_r, tail_r, entry_n, head_out;
  logic [1:0]                count_r;

  assign entry_n = {enq_inst_i, enq_pc_i, enq_pred_i};

  // Deq is only issued with a valid head, and enq at count 2 only alongside a deq.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 2'd0;
    end else if (flush_i) begin
      count_r <= 2'd0;
    end else begin
      case ({enq_i, deq_i})
        2'b10: begin
          if (count_r == 2'd0) head_r <= entry_n;
          else                 tail_r <= entry_n;
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_r <= entry_n;
          end else begin
            head_r <= tail_r;
            tail_r <= entry_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign v_o      = (count_r != 2'd0);
  assign head_out = v_o ? head_r : '0;
  assign {inst_o, pc_o, pred_o} = head_out;
  assign count_o  = count_r;

endmodule

// File: rtl/bp_cce_fetch_ctrl.sv
// CCE microcode fetch sequencer: issues instruction-RAM reads, predecodes returned words for
// static branch prediction, buffers two instructions and redirects on execute mispredicts.
module bp_cce_fetch_ctrl
  import bp_cce_pkg::*;
#(
  parameter int cce_pc_width_p   = 8,
  parameter int cce_inst_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic [cce_pc_width_p-1:0]   boot_pc_i,
  output logic                        ram_v_o,
  output logic [cce_pc_width_p-1:0]   ram_addr_o,
  input  logic [cce_inst_width_p-1:0] ram_data_i,
  output logic                        inst_v_o,
  output logic [cce_inst_width_p-1:0] inst_o,
  output logic [cce_pc_width_p-1:0]   inst_pc_o,
  output logic                        predicted_taken_o,
  input  logic                        inst_yumi_i,
  input  logic                        mispredict_i,
  input  logic [cce_pc_width_p-1:0]   redirect_pc_i
);

  bp_cce_fetch_state_e         state_r, state_n;
  logic                        pending_r;
  logic [cce_pc_width_p-1:0]   pending_pc_r, fetch_pc_r, fetch_pc_n;
  logic                        enq, deq, flush;
  logic [1:0]                  count;
  logic [2:0]                  count_next;
  logic                        pred_taken;
  logic [cce_pc_width_p-1:0]   pred_next_pc;

  assign pred_taken   = ram_data_i[cce_inst_branch_bit_lp] & ram_data_i[cce_inst_pred_taken_bit_lp];
  assign pred_next_pc = pred_taken ? ram_data_i[cce_inst_target_lsb_lp +: cce_pc_width_p]
                                   : pending_pc_r + cce_pc_width_p'(1);

  always_comb begin
    state_n    = state_r;
    ram_v_o    = 1'b0;
    ram_addr_o = '0;
    fetch_pc_n = fetch_pc_r;
    enq        = 1'b0;
    deq        = 1'b0;
    flush      = 1'b0;
    count_next = {1'b0, count};
    case (state_r)
      e_fetch_wait_start: begin
        if (start_i) begin
          ram_v_o    = 1'b1;
          ram_addr_o = boot_pc_i;
          fetch_pc_n = boot_pc_i + cce_pc_width_p'(1);
          state_n    = e_fetch_run;
        end
      end
      e_fetch_run: begin
        if (mispredict_i) begin
          flush      = 1'b1;
          ram_v_o    = 1'b1;
          ram_addr_o = redirect_pc_i;
          fetch_pc_n = redirect_pc_i + cce_pc_width_p'(1);
        end else begin
          enq        = pending_r;
          deq        = inst_yumi_i & inst_v_o;
          count_next = {1'b0, count} + {2'b00, pending_r} - {2'b00, deq};
          // Reading only when the buffer will have a free slot next cycle keeps enq-at-full impossible.
          ram_v_o    = (count_next <= 3'd1);
          ram_addr_o = pending_r ? pred_next_pc : fetch_pc_r;
          if (pending_r) fetch_pc_n = pred_next_pc;
        end
      end
      default: state_n = e_fetch_wait_start;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= e_fetch_wait_start;
      pending_r    <= 1'b0;
      pending_pc_r <= '0;
      fetch_pc_r   <= '0;
    end else begin
      state_r    <= state_n;
      pending_r  <= ram_v_o;
      fetch_pc_r <= fetch_pc_n;
      if (ram_v_o) pending_pc_r <= ram_addr_o;
    end
  end

  bp_cce_fetch_buffer #(
    .inst_width_p(cce_inst_width_p),
    .pc_width_p  (cce_pc_width_p)
  ) buffer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .flush_i   (flush),
    .enq_i     (enq),
    .enq_inst_i(ram_data_i),
    .enq_pc_i  (pending_pc_r),
    .enq_pred_i(pred_taken),
    .deq_i     (deq),
    .v_o       (inst_v_o),
    .inst_o    (inst_o),
    .pc_o      (inst_pc_o),
    .pred_o    (predicted_taken_o),
    .count_o   (count)
  );

  // Execute-side protocol checks.
  assert property (@(posedge clk_i) disable iff (!reset_n_i) inst_yumi_i |-> inst_v_o);
  assert property (@(posedge clk_i) disable iff (!reset_n_i) inst_v_o |-> !$isunknown(inst_o));

endmodule
